mant_mul_arbiter: RTL and testbench

Round-robin arbiter and issue sequencer that shares one fully pipelined, fixed-latency mantissa multiplier among `NUM_REQ` requesters. The shared multiplier is the radix-4 Booth partial-product generator, the reduction tree and the final adder. It sits between the dot-product lanes' FP multiply front-ends and that multiplier. Each cycle it accepts at most one operand pair, issues the pair from a register, tracks the owner through the multiplier latency with a tag pipeline, and returns each product to its owner.

---
 rtl/mant_mul_arbiter.sv | 140 ++++++++++++++
 tb/tb_mant_mul_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mant_mul_arbiter.sv
// Round-robin arbiter and issue sequencer that shares one fixed-latency pipelined mantissa
// multiplier among NUM_REQ requesters and returns each product to its owner in grant order.
module mant_mul_arbiter #(
    parameter int unsigned PARM_MANT = 23,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MUL_LAT   = 3
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic                             enable_i,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    input  logic [NUM_REQ*(PARM_MANT+1)-1:0] req_mant_a_i,
    input  logic [NUM_REQ*(PARM_MANT+1)-1:0] req_mant_b_i,
    output logic                             mul_valid_o,
    output logic [PARM_MANT:0]               mul_mant_a_o,
    output logic [PARM_MANT:0]               mul_mant_b_o,
    input  logic [2*PARM_MANT+1:0]           mul_prod_i,
    output logic [NUM_REQ-1:0]               rsp_valid_o,
    output logic [2*PARM_MANT+1:0]           rsp_prod_o,
    output logic                             busy_o
);

    localparam int unsigned OpW   = PARM_MANT + 1;
    localparam int unsigned ProdW = 2 * PARM_MANT + 2;
    localparam int unsigned IdxW  = $clog2(NUM_REQ);
    localparam int unsigned SumW  = IdxW + 1;

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic            grant_vld;
    logic [IdxW-1:0] grant_idx;
    logic [SumW-1:0] scan_sum;

    logic            mul_valid_q, mul_valid_d;
    logic [OpW-1:0]  mul_a_q, mul_a_d;
    logic [OpW-1:0]  mul_b_q, mul_b_d;
    logic [IdxW-1:0] iss_idx_q, iss_idx_d;

    logic [MUL_LAT-1:0]           tag_vld_q, tag_vld_d;
    logic [MUL_LAT-1:0][IdxW-1:0] tag_idx_q, tag_idx_d;

    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [ProdW-1:0]   rsp_prod_q, rsp_prod_d;

    logic [OpW-1:0] op_a [NUM_REQ];
    logic [OpW-1:0] op_b [NUM_REQ];

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
        assign op_a[r] = req_mant_a_i[r*OpW +: OpW];
        assign op_b[r] = req_mant_b_i[r*OpW +: OpW];
    end

    // Scan upward from ptr with wrap; first valid requester wins. Reset blocks grants too.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_sum = {1'b0, ptr_q} + SumW'(i);
            if (scan_sum >= SumW'(NUM_REQ)) begin
                scan_sum = scan_sum - SumW'(NUM_REQ);
            end
            if (enable_i && rst_n_i && !grant_vld && req_valid_i[scan_sum[IdxW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan_sum[IdxW-1:0];
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (grant_vld) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        mul_valid_d = grant_vld;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        iss_idx_d   = iss_idx_q;
        if (grant_vld) begin
            ptr_d     = (grant_idx == IdxW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            mul_a_d   = op_a[grant_idx];
            mul_b_d   = op_b[grant_idx];
            iss_idx_d = grant_idx;
        end
    end

    // Owner tags travel alongside the multiplier; the last stage lines up with mul_prod_i.
    if (MUL_LAT == 1) begin : g_tag_lat1
        assign tag_vld_d = mul_valid_q;
        assign tag_idx_d = iss_idx_q;
    end else begin : g_tag_latn
        assign tag_vld_d = {tag_vld_q[MUL_LAT-2:0], mul_valid_q};
        assign tag_idx_d = {tag_idx_q[MUL_LAT-2:0], iss_idx_q};
    end

    always_comb begin
        rsp_valid_d = '0;
        rsp_prod_d  = rsp_prod_q;
        if (tag_vld_q[MUL_LAT-1]) begin
            rsp_valid_d[tag_idx_q[MUL_LAT-1]] = 1'b1;
            rsp_prod_d                        = mul_prod_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ptr_q       <= '0;
            mul_valid_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            iss_idx_q   <= '0;
            tag_vld_q   <= '0;
            tag_idx_q   <= '0;
            rsp_valid_q <= '0;
            rsp_prod_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            mul_valid_q <= mul_valid_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            iss_idx_q   <= iss_idx_d;
            tag_vld_q   <= tag_vld_d;
            tag_idx_q   <= tag_idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_prod_q  <= rsp_prod_d;
        end
    end

    assign mul_valid_o  = mul_valid_q;
    assign mul_mant_a_o = mul_a_q;
    assign mul_mant_b_o = mul_b_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_prod_o   = rsp_prod_q;
    assign busy_o       = mul_valid_q | (|tag_vld_q) | (|rsp_valid_q);

endmodule

// File: tb/tb_mant_mul_arbiter.sv
// Directed bench for mant_mul_arbiter: a 3-stage multiplier model feeds mul_prod_i and a
// per-cycle table of expected responses is filled from hand-computed products.
module tb_mant_mul_arbiter;

    localparam int unsigned PARM_MANT = 23;
    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned MUL_LAT   = 3;
    localparam int          RSP_LAT   = 5;
    localparam int          TBL       = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [95:0] req_mant_a;
    logic [95:0] req_mant_b;
    logic        mul_valid;
    logic [23:0] mul_a;
    logic [23:0] mul_b;
    logic [47:0] mul_prod;
    logic [3:0]  rsp_valid;
    logic [47:0] rsp_prod;
    logic        busy;

    always #5 clk = ~clk;

    mant_mul_arbiter #(
        .PARM_MANT (PARM_MANT),
        .NUM_REQ   (NUM_REQ),
        .MUL_LAT   (MUL_LAT)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .enable_i     (enable),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_mant_a_i (req_mant_a),
        .req_mant_b_i (req_mant_b),
        .mul_valid_o  (mul_valid),
        .mul_mant_a_o (mul_a),
        .mul_mant_b_o (mul_b),
        .mul_prod_i   (mul_prod),
        .rsp_valid_o  (rsp_valid),
        .rsp_prod_o   (rsp_prod),
        .busy_o       (busy)
    );

    logic [23:0] op_a   [4];
    logic [23:0] op_b   [4];
    logic [47:0] exp_of [4];

    assign req_mant_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
    assign req_mant_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

    logic [47:0] mpipe [MUL_LAT];
    always @(posedge clk) begin
        mpipe[0] <= 48'(mul_a) * 48'(mul_b);
        for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_prod = mpipe[MUL_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0]  exp_vld  [TBL];
    logic [47:0] exp_prod [TBL];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          chk_en   = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every cycle after reset release, the response port must match the expectation table.
    always @(negedge clk) begin
        if (chk_en && cyc < TBL) begin
            check_eq("rsp_valid", 64'(rsp_valid), 64'(exp_vld[cyc]));
            if (exp_vld[cyc] != 4'b0) check_eq("rsp_prod", 64'(rsp_prod), 64'(exp_prod[cyc]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int r, input logic [23:0] a, input logic [23:0] b,
                           input logic [47:0] p);
        op_a[r]   = a;
        op_b[r]   = b;
        exp_of[r] = p;
    endtask

    task automatic expect_grant(input logic [3:0] exp_rdy, input string tag);
        @(negedge clk);
        check_eq(tag, 64'(req_ready), 64'(exp_rdy));
        for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i] && cyc + RSP_LAT < TBL) begin
                exp_vld[cyc + RSP_LAT]  = exp_rdy;
                exp_prod[cyc + RSP_LAT] = exp_of[i];
            end
        end
    endtask

    task automatic cycle_req(input logic [3:0] vld, input logic [3:0] exp_rdy, input string tag);
        req_valid = vld;
        expect_grant(exp_rdy, tag);
        step();
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_mul_valid"}, 64'(mul_valid), 64'(0));
        check_eq({tag, "_mul_a"}, 64'(mul_a), 64'(0));
        check_eq({tag, "_mul_b"}, 64'(mul_b), 64'(0));
        check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        check_eq({tag, "_rsp_prod"}, 64'(rsp_prod), 64'(0));
        check_eq({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        for (int i = 0; i < TBL; i++) begin
            exp_vld[i]  = 4'b0;
            exp_prod[i] = 48'h0;
        end
        rst_n     = 1'b0;
        enable    = 1'b1;
        req_valid = 4'b0;
        set_ops(0, 24'h800000, 24'h800000, 48'h400000000000);
        set_ops(1, 24'h000003, 24'h000005, 48'h00000000000F);
        set_ops(2, 24'h000100, 24'h000100, 48'h000000010000);
        set_ops(3, 24'hFFFFFF, 24'h000002, 48'h000001FFFFFE);

        // Reset: no grant even with every request raised, all outputs zero.
        step();
        step();
        req_valid = 4'hF;
        @(negedge clk);
        check_eq("ready_in_reset", 64'(req_ready), 64'(0));
        check_idle_outputs("reset");
        step();
        rst_n     = 1'b1;
        req_valid = 4'b0;
        chk_en    = 1'b1;

        // Single request from requester 0.
        req_valid = 4'b0001;
        expect_grant(4'b0001, "single_grant");
        step();
        req_valid = 4'b0;
        @(negedge clk);
        check_eq("single_mul_valid", 64'(mul_valid), 64'(1));
        check_eq("single_mul_a", 64'(mul_a), 64'h800000);
        check_eq("single_mul_b", 64'(mul_b), 64'h800000);
        check_eq("single_ready_after", 64'(req_ready), 64'(0));
        check_eq("single_busy", 64'(busy), 64'(1));
        step();
        repeat (6) step();
        @(negedge clk);
        check_eq("busy_idle", 64'(busy), 64'(0));
        step();

        // ptr=1, only requester 3 valid: scan must skip 1,2 and land on 3, leaving ptr=0.
        cycle_req(4'b1000, 4'b1000, "wrap_grant");

        // All four valid continuously.
        for (int k = 0; k < 8; k++) begin
            logic [3:0] oh;
            oh = 4'b0001 << (k % 4);
            cycle_req(4'b1111, oh, "rr_grant");
        end
        req_valid = 4'b0;
        repeat (6) step();

        // Sparse requests from 1 and 3.
        for (int k = 0; k < 4; k++) begin
            cycle_req(4'b1010, (k % 2 == 1) ? 4'b1000 : 4'b0010, "sparse_grant");
        end
        req_valid = 4'b0;
        repeat (6) step();

        // Back-to-back maximum operands.
        set_ops(0, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
        for (int k = 0; k < 6; k++) cycle_req(4'b0001, 4'b0001, "max_grant");
        req_valid = 4'b0;
        repeat (4) step();
        @(negedge clk);
        check_eq("busy_last_rsp", 64'(busy), 64'(1));
        step();
        @(negedge clk);
        check_eq("busy_fall", 64'(busy), 64'(0));
        step();

        // Enable low while requester 2 waits; requester 1's response lands inside the window.
        cycle_req(4'b0010, 4'b0010, "en_pre_grant");
        req_valid = 4'b0;
        step();
        step();
        enable    = 1'b0;
        req_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            expect_grant(4'b0000, "en_low_ready");
            step();
        end
        enable = 1'b1;
        expect_grant(4'b0100, "en_resume_grant");
        step();
        req_valid = 4'b0;
        repeat (7) step();

        // Reset two cycles after a handshake drops that operation.
        cycle_req(4'b0010, 4'b0010, "pre_reset_grant");
        req_valid = 4'b0;
        step();
        rst_n     = 1'b0;
        req_valid = 4'b1010;
        for (int i = 1; i <= 6; i++) exp_vld[cyc + i] = 4'b0;
        expect_grant(4'b0000, "ready_in_reset2");
        step();
        rst_n = 1'b1;
        // ptr was 2 before reset; scanning from 0 must pick requester 1, not 3.
        expect_grant(4'b0010, "post_reset_grant");
        check_idle_outputs("post_reset");
        step();
        req_valid = 4'b0;
        repeat (7) step();
        @(negedge clk);
        check_eq("final_busy", 64'(busy), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
